// File: rtl/tdc_pkg.sv
// rtl/tdc_pkg.sv - shared FSM encoding, LFSR constants and helpers for the TDC hit generator
//
// Contents:
//   state_t    : sequencer states IDLE / HIGH / LOW / GAP / FINISH
//   LFSR_TAPS  : Galois tap mask for x^16 + x^14 + x^13 + x^11 + 1 (right-shifting form)
//   LFSR_SEED  : default LFSR reset value
//   max3       : elaboration-time helper for sizing the shared phase counter
package tdc_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_HIGH   = 3'd1,
        ST_LOW    = 3'd2,
        ST_GAP    = 3'd3,
        ST_FINISH = 3'd4
    } state_t;

    localparam logic [15:0] LFSR_TAPS = 16'hB400;
    localparam logic [15:0] LFSR_SEED = 16'hACE1;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/tdc_lfsr16.sv
// rtl/tdc_lfsr16.sv - 16-bit Galois LFSR used as the pulse-width jitter source
//
// Ports:
//   clk : system clock, rising edge
//   rst : synchronous active-high reset, loads SEED
//   en  : advance one step this cycle
//   q   : current LFSR state
module tdc_lfsr16 import tdc_pkg::*; #(
    parameter logic [15:0] SEED = LFSR_SEED
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    output logic [15:0] q
);

    always_ff @(posedge clk) begin
        if (rst) begin
            q <= SEED;
        end else if (en) begin
            // Shift right; when the bit falling out is 1, fold the taps back in.
            q <= {1'b0, q[15:1]} ^ (q[0] ? LFSR_TAPS : 16'h0000);
        end
    end

endmodule

// File: rtl/tdc_hit_gen.sv
// rtl/tdc_hit_gen.sv - programmable burst/continuous hit pulse generator with width jitter
//
// Ports:
//   clk       : system clock, rising edge
//   rst       : synchronous active-high reset, dominates every input
//   start     : one-cycle request to begin a sequence (honoured only in IDLE)
//   abort     : ends a running sequence at the next edge
//   mode_cont : 0 = burst of NUM_HITS pulses, 1 = run until abort
//   mode_rr   : 0 = all enabled channels together, 1 = round-robin over enabled channels
//   ch_mask   : channel enables, captured with an accepted start
//   hit       : registered hit pulses
//   busy      : sequence running (HIGH/LOW/GAP)
//   done      : one-cycle pulse after the FINISH state
//   hit_count : completed pulses in the current/last sequence, wraps at 2^16
module tdc_hit_gen import tdc_pkg::*; #(
    parameter int          NUM_CH   = 4,
    parameter int          NUM_HITS = 32,
    parameter int          HIGH_CYC = 20,
    parameter int          LOW_CYC  = 20,
    parameter int          GAP_CYC  = 10,
    parameter int          JIT_W    = 5,
    parameter logic [15:0] SEED     = LFSR_SEED
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic              mode_cont,
    input  logic              mode_rr,
    input  logic [NUM_CH-1:0] ch_mask,
    output logic [NUM_CH-1:0] hit,
    output logic              busy,
    output logic              done,
    output logic [15:0]       hit_count
);

    localparam int          LEN_MAX  = max3(HIGH_CYC + (1 << JIT_W), LOW_CYC, GAP_CYC);
    localparam int          CNT_W    = $clog2(LEN_MAX + 1);
    localparam int          PTR_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam logic [15:0] JIT_MASK = 16'((32'd1 << JIT_W) - 32'd1);

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [NUM_CH-1:0]  mask_q, mask_d;
    logic               cont_q, cont_d;
    logic               rr_q, rr_d;
    logic [PTR_W-1:0]   ptr_q, ptr_d;
    logic [15:0]        count_d;
    logic [NUM_CH-1:0]  hit_d;
    logic               busy_d, done_d;
    logic               lfsr_en;
    logic [15:0]        lfsr_q;
    logic [CNT_W-1:0]   high_len;
    logic               enter_high, seq_next;

    tdc_lfsr16 #(.SEED(SEED)) u_lfsr (
        .clk (clk),
        .rst (rst),
        .en  (lfsr_en),
        .q   (lfsr_q)
    );

    // Counter holds (length - 1) so a phase ends on the cycle it reads zero.
    assign high_len = CNT_W'(HIGH_CYC - 1) + CNT_W'(lfsr_q & JIT_MASK);

    // First set bit strictly after 'from', wrapping MSB to LSB. Passing
    // from = NUM_CH-1 yields the lowest set bit.
    function automatic logic [PTR_W-1:0] next_set(input logic [NUM_CH-1:0] m, input int from);
        logic [PTR_W-1:0] r;
        int idx;
        r = '0;
        for (int i = NUM_CH; i >= 1; i--) begin
            idx = (from + i) % NUM_CH;
            if (m[idx]) r = PTR_W'(idx);
        end
        return r;
    endfunction

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        mask_d     = mask_q;
        cont_d     = cont_q;
        rr_d       = rr_q;
        ptr_d      = ptr_q;
        count_d    = hit_count;
        lfsr_en    = 1'b0;
        enter_high = 1'b0;
        seq_next   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start && !abort) begin
                    count_d = '0;
                    if (|ch_mask) begin
                        mask_d     = ch_mask;
                        cont_d     = mode_cont;
                        rr_d       = mode_rr;
                        ptr_d      = next_set(ch_mask, NUM_CH - 1);
                        enter_high = 1'b1;
                    end else begin
                        state_d = ST_FINISH;
                    end
                end
            end
            ST_HIGH: begin
                if (cnt_q == '0) begin
                    state_d = ST_LOW;
                    cnt_d   = CNT_W'(LOW_CYC - 1);
                    count_d = hit_count + 16'd1;
                    ptr_d   = next_set(mask_q, int'(ptr_q));
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_LOW: begin
                if (cnt_q == '0) begin
                    if (GAP_CYC > 0) begin
                        state_d = ST_GAP;
                        cnt_d   = CNT_W'(GAP_CYC - 1);
                    end else begin
                        seq_next = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_GAP: begin
                if (cnt_q == '0) seq_next = 1'b1;
                else             cnt_d    = cnt_q - 1'b1;
            end
            ST_FINISH: state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase

        if (seq_next) begin
            if (!cont_q && hit_count == 16'(NUM_HITS)) state_d = ST_FINISH;
            else                                       enter_high = 1'b1;
        end

        // The LFSR steps exactly once per HIGH entry; the value before the step sets the width.
        if (enter_high) begin
            state_d = ST_HIGH;
            cnt_d   = high_len;
            lfsr_en = 1'b1;
        end

        // Abort freezes the count, so a truncated pulse is never counted.
        if (abort && (state_q == ST_HIGH || state_q == ST_LOW || state_q == ST_GAP)) begin
            state_d = ST_FINISH;
            cnt_d   = cnt_q;
            count_d = hit_count;
            ptr_d   = ptr_q;
            lfsr_en = 1'b0;
        end

        hit_d = '0;
        if (state_d == ST_HIGH) hit_d = rr_d ? (NUM_CH'(1) << ptr_d) : mask_d;
        busy_d = (state_d == ST_HIGH) || (state_d == ST_LOW) || (state_d == ST_GAP);
        done_d = (state_q == ST_FINISH);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            mask_q    <= '0;
            cont_q    <= 1'b0;
            rr_q      <= 1'b0;
            ptr_q     <= '0;
            hit_count <= '0;
            hit       <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            mask_q    <= mask_d;
            cont_q    <= cont_d;
            rr_q      <= rr_d;
            ptr_q     <= ptr_d;
            hit_count <= count_d;
            hit       <= hit_d;
            busy      <= busy_d;
            done      <= done_d;
        end
    end

endmodule
